// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver: locks to an incoming HS/VS/BLANK_n stream, measures its timing
// and recovers active-pixel coordinates.
module vga_timing_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        HS,
  input  logic        VS,
  input  logic        BLANK_n,
  output logic [10:0] CoorX,
  output logic [9:0]  CoorY,
  output logic        pix_valid,
  output logic        locked,
  output logic        frame_start,
  output logic        lock_err,
  output logic [10:0] h_total_meas,
  output logic [9:0]  v_total_meas
);
  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [9:0]  VT = 10'(V_TOTAL);
  localparam logic [9:0]  VA = 10'(V_ACTIVE);
  localparam logic [2:0]  LF = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state;

  logic hs_r, vs_r, bl_r, hs_d, vs_d, bl_d, seen_hs, frame_ok;
  logic [10:0] h_cnt, x_cnt, x_cur;
  logic [9:0] line_cnt, y_cnt, y_cur;
  logic [2:0] good_cnt;
  logic ls, fs, bl_fall, sat, line_bad, width_bad, good, err, pv;

  assign ls        = hs_d & ~hs_r;
  assign fs        = vs_d & ~vs_r;
  assign bl_fall   = bl_d & ~bl_r;
  assign sat       = (h_cnt == '1) & ~ls;
  // the very first HS fall after reset ends a line of unknown length
  assign line_bad  = ls & seen_hs & (h_cnt + 11'd1 != HT);
  assign width_bad = ls & (x_cnt != '0) & (x_cnt != HA);
  assign good      = frame_ok & ~line_bad & ~width_bad & (line_cnt + 10'd1 == VT) & (y_cnt == VA);
  assign err       = (state == LOCKED) & (line_bad | width_bad | (fs & ~good) | sat);
  assign pv        = (state == LOCKED) & bl_r;
  assign x_cur     = ls ? '0 : x_cnt;
  assign y_cur     = fs ? '0 : y_cnt;

  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      {hs_r, vs_r, bl_r, hs_d, vs_d, bl_d} <= '0;
      {seen_hs, frame_ok}                  <= '0;
      {h_cnt, x_cnt, line_cnt, y_cnt}      <= '0;
      good_cnt     <= '0;
      state        <= SEARCH;
      CoorX        <= HA;
      CoorY        <= VA;
      pix_valid    <= 1'b0;
      locked       <= 1'b0;
      frame_start  <= 1'b0;
      lock_err     <= 1'b0;
      h_total_meas <= '0;
      v_total_meas <= '0;
    end else begin
      {hs_r, vs_r, bl_r} <= {HS, VS, BLANK_n};
      {hs_d, vs_d, bl_d} <= {hs_r, vs_r, bl_r};
      h_cnt    <= ls ? '0 : (h_cnt == '1 ? h_cnt : h_cnt + 11'd1);
      x_cnt    <= x_cur + {10'd0, bl_r};
      y_cnt    <= y_cur + {9'd0, bl_fall};
      line_cnt <= fs ? '0 : line_cnt + {9'd0, ls};
      if (ls) seen_hs <= 1'b1;
      if (ls & seen_hs) h_total_meas <= h_cnt + 11'd1;
      if (fs) v_total_meas <= line_cnt + 10'd1;
      frame_ok    <= fs | (frame_ok & ~line_bad & ~width_bad);
      frame_start <= fs;
      lock_err    <= err;
      pix_valid   <= pv;
      CoorX       <= pv ? x_cur : HA;
      CoorY       <= pv ? y_cur : VA;
      locked      <= state == LOCKED;
      if (sat | err) begin
        state    <= SEARCH;
        good_cnt <= '0;
      end else if (fs && state == SEARCH) begin
        state    <= MEASURE;
        good_cnt <= '0;
      end else if (fs && state == MEASURE) begin
        good_cnt <= good ? good_cnt + 3'd1 : '0;
        if (good && good_cnt + 3'd1 == LF) state <= LOCKED;
      end
    end
endmodule
